// File: rtl/hilo_muldiv_pkg.sv
// Shared op encodings, FSM states and iteration count for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FINISH
   } md_state_t;

   // Magnitude of a two's-complement operand when the op is signed.
   function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide on {acc, lo}.
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic            i_mul,
   input  logic [XLEN-1:0] i_acc,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_acc,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_trial;

   assign w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_b} : '0);
   assign w_shift = {i_acc, i_lo[XLEN-1]};
   // Partial remainder is always below the divisor, so the 33-bit borrow is a valid sign.
   assign w_trial = w_shift - {1'b0, i_b};

   always_comb begin
      o_acc = w_shift[XLEN-1:0];
      o_lo  = {i_lo[XLEN-2:0], 1'b0};
      if (i_mul) begin
         o_acc = w_sum[XLEN:1];
         o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
      end else if (!w_trial[XLEN]) begin
         o_acc = w_trial[XLEN-1:0];
         o_lo  = {i_lo[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS32 HI/LO registers with an iterative multiply/divide engine.
// Define HILO_MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int DW = 2 * XLEN;

   md_state_t       r_state, w_state_nxt;
   logic [XLEN-1:0] r_acc, r_qr, r_b, r_hi, r_lo;
   logic [5:0]      r_cnt;
   logic            r_mul, r_neg_q, r_neg_r, r_dz, r_done, r_div_zero;

   logic            w_idle, w_is_mul, w_is_div, w_signed, w_go, w_mt, w_fast;
   logic [XLEN-1:0] w_a_abs, w_b_abs, w_step_acc, w_step_lo, w_quo, w_rem;
   logic [DW-1:0]   w_prod, w_prod_s, w_fast_prod;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_is_mul = (op == MD_MULT) || (op == MD_MULTU);
   assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
   assign w_signed = (op == MD_MULT) || (op == MD_DIV);
   assign w_go     = start && w_idle && (w_is_mul || w_is_div);
   assign w_mt     = start && w_idle && ((op == MD_MTHI) || (op == MD_MTLO));
   assign w_a_abs  = md_abs(rs_val, w_signed);
   assign w_b_abs  = md_abs(rt_val, w_signed);

`ifdef HILO_MULDIV_FAST_MUL_EN
   assign w_fast      = w_is_mul;
   assign w_fast_prod = DW'(w_a_abs) * DW'(w_b_abs);
`else
   assign w_fast      = 1'b0;
   assign w_fast_prod = '0;
`endif

   muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .i_mul (r_mul),
      .i_acc (r_acc),
      .i_lo  (r_qr),
      .i_b   (r_b),
      .o_acc (w_step_acc),
      .o_lo  (w_step_lo)
   );

   // Engine runs on magnitudes; signs are restored on the way into HI/LO.
   assign w_prod   = {r_acc, r_qr};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quo    = r_dz ? '1 : (r_neg_q ? -r_qr : r_qr);
   assign w_rem    = r_neg_r ? -r_acc : r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_go) w_state_nxt = w_fast ? ST_FINISH : ST_RUN;
         ST_RUN:    if (r_cnt == 6'(MD_ITER - 1)) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc      <= '0;
         r_qr       <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         r_mul      <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FINISH);
         if (w_go) begin
            r_acc      <= w_fast ? w_fast_prod[DW-1:XLEN] : '0;
            r_qr       <= w_fast ? w_fast_prod[XLEN-1:0] : w_a_abs;
            r_b        <= w_b_abs;
            r_cnt      <= '0;
            r_mul      <= w_is_mul;
            r_neg_q    <= w_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            r_neg_r    <= w_signed && rs_val[XLEN-1];
            r_dz       <= w_is_div && (rt_val == '0);
            r_div_zero <= 1'b0;
         end else if (r_state == ST_RUN) begin
            r_acc <= w_step_acc;
            r_qr  <= w_step_lo;
            r_cnt <= r_cnt + 6'd1;
         end else if (r_state == ST_FINISH) begin
            r_div_zero <= r_dz;
            if (r_mul) begin
               r_hi <= w_prod_s[DW-1:XLEN];
               r_lo <= w_prod_s[XLEN-1:0];
            end else begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end
         end
         if (w_mt) begin
            r_div_zero <= 1'b0;
            if (op == MD_MTHI) r_hi <= rs_val;
            else               r_lo <= rs_val;
         end
      end
   end

   assign busy     = !w_idle;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: arithmetic reference model compared every cycle, plus literal directed checks.
module tb_hilo_muldiv;
   import hilo_muldiv_pkg::*;

`ifdef HILO_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;

   hilo_muldiv dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } res_t;

   // Architectural result from plain integer arithmetic.
   function automatic res_t ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      res_t        r;
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      r  = '0;
      sa = int'(a);
      sb = int'(b);
      case (o)
         MD_MULT: begin
            sp = longint'(sa) * longint'(sb);
            {r.hi, r.lo} = 64'(sp);
         end
         MD_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            {r.hi, r.lo} = up;
         end
         MD_DIV, MD_DIVU: begin
            if (b == 32'd0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
            end else if (o == MD_DIVU) begin
               r.lo = a / b; r.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.lo = 32'h8000_0000; r.hi = 32'd0;
            end else begin
               r.lo = 32'(sa / sb); r.hi = 32'(sa % sb);
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   logic [31:0] m_hi, m_lo;
   logic        m_busy, m_done, m_dz;
   int          m_left;
   res_t        m_p;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         m_left <= 0; m_p <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_hi <= m_p.hi; m_lo <= m_p.lo; m_dz <= m_p.dz;
               m_busy <= 1'b0; m_done <= 1'b1;
            end
            m_left <= m_left - 1;
         end else if (start) begin
            if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) begin
               m_p    <= ref_op(op, rs_val, rt_val);
               m_left <= (op == MD_MULT || op == MD_MULTU) ? MUL_LAT : DIV_LAT;
               m_busy <= 1'b1;
               m_dz   <= 1'b0;
            end else if (op == MD_MTHI) begin
               m_hi <= rs_val; m_dz <= 1'b0;
            end else if (op == MD_MTLO) begin
               m_lo <= rs_val; m_dz <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy", 64'(busy), 64'(m_busy));
         chk("cyc_done", 64'(done), 64'(m_done));
         chk("cyc_div_zero", 64'(div_zero), 64'(m_dz));
         chk("cyc_hi", 64'(hi), 64'(m_hi));
         chk("cyc_lo", 64'(lo), 64'(m_lo));
      end
   end

   // Issue one op at a negedge and wait (bounded) for done; checks the edge count to the result.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int exp_lat);
      int n;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n - 1), 64'(exp_lat));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_zero), 64'd0);

      start = 1'b1; op = MD_MTHI; rs_val = 32'h1234_5678;
      @(negedge clk);
      chk("mthi", 64'(hi), 64'h1234_5678);
      op = MD_MTLO; rs_val = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
      chk("mt_hi_kept", 64'(hi), 64'h1234_5678);

      do_op(MD_MULT, 32'hFFFF_FFFF, 32'd5, MUL_LAT);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFFB);
      do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
      chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0001);
      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
      do_op(MD_DIVU, 32'd7, 32'd0, DIV_LAT);
      chk("dz_flag", 64'(div_zero), 64'd1);
      chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("dz_hi", 64'(hi), 64'd7);
      do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
      chk("ovf_lo", 64'(lo), 64'h8000_0000);
      chk("ovf_hi", 64'(hi), 64'd0);
      chk("ovf_dz", 64'(div_zero), 64'd0);

      // Reset during RUN discards the divide.
      start = 1'b1; op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);

      // A start issued mid-RUN must not disturb the running divide.
      start = 1'b1; op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; op = MD_MULTU; rs_val = 32'h0001_0000; rt_val = 32'h0001_0001;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 100 && !done; n++) @(negedge clk);
      chk("ign_done", 64'(done), 64'd1);
      chk("ign_lo", 64'(lo), 64'd14);
      chk("ign_hi", 64'(hi), 64'd2);

      start = 1'b1; op = 3'd6; rs_val = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
      chk("undef_busy", 64'(busy), 64'd0);
      chk("undef_hi", 64'(hi), 64'd2);

      for (int i = 0; i < 4000; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         op     = 3'($urandom_range(0, 7));
         rs_val = pick();
         rt_val = pick();
         @(negedge clk);
      end
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("end_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
